// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    // Transaction state of the single memory port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        LS_WAIT = 2'd2,
        IF_DROP = 2'd3
    } arb_state_e;

    // Arbitration winner encoding.
    localparam logic ARB_LS = 1'b0;
    localparam logic ARB_IF = 1'b1;

    // Starvation counter width; wide enough for limits up to 15.
    localparam int CNT_W = 4;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_starve_cnt.sv
// Counts consecutive load/store grants taken while a fetch was waiting.
module arb_starve_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_grant,
    input  logic i_grant_if,
    input  logic i_if_pending,
    output logic o_at_lim
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: only a grant moves the counter; an LS grant over a waiting fetch adds one.
    always_comb begin
        cnt_d = cnt_q;
        if (i_grant) begin
            if (!i_grant_if && i_if_pending) cnt_d = sat_inc(cnt_q, LIM);
            else                             cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_at_lim = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction in flight, with flush abort and bounded fetch starvation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_flush,
    output logic                o_if_ack,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_ls_req,
    input  logic                i_ls_wren,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_bmask,
    output logic                o_ls_ack,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_m_req,
    output logic                o_m_wren,
    output logic [ADDR_W-1:0]   o_m_addr,
    output logic [DATA_W-1:0]   o_m_wdata,
    output logic [DATA_W/8-1:0] o_m_bmask,
    input  logic                i_m_gnt,
    input  logic                i_m_rvalid,
    input  logic [DATA_W-1:0]   i_m_rdata,
    output logic                o_stall_if,
    output logic                o_stall_mem
);

    localparam int BM_W = DATA_W / 8;

    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BM_W-1:0]   bmask;
    } mem_req_t;

    arb_state_e        state_q, state_d;
    logic              if_ack_q, if_ack_d;
    logic              ls_ack_q, ls_ack_d;
    logic              ls_wren_q, ls_wren_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              if_v, ls_v, at_lim, winner, m_req, grant;
    mem_req_t          req;

    // A request already acknowledged this cycle must not be issued again.
    assign if_v   = i_if_req & ~i_if_flush & ~if_ack_q;
    assign ls_v   = i_ls_req & ~ls_ack_q;
    // LS is the older instruction and wins unless the fetch has waited too long or is alone.
    assign winner = (if_v && (at_lim || !ls_v)) ? ARB_IF : ARB_LS;
    assign grant  = m_req & i_m_gnt;

    arb_starve_cnt #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_grant      (grant),
        .i_grant_if   (winner == ARB_IF),
        .i_if_pending (if_v),
        .o_at_lim     (at_lim)
    );

    // State register and registered responses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            ls_wren_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge values.
            state_q    <= state_d;
            if_ack_q   <= if_ack_d;
            ls_ack_q   <= ls_ack_d;
            ls_wren_q  <= ls_wren_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Next state: issue on grant, complete on rvalid, divert a flushed fetch to IF_DROP.
    always_comb begin
        // NOTE: hold-value defaults ahead of the case keep this purely combinational.
        state_d    = state_q;
        if_ack_d   = 1'b0;
        ls_ack_d   = 1'b0;
        ls_wren_d  = ls_wren_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    if (winner == ARB_IF) begin
                        state_d = IF_WAIT;
                    end else begin
                        state_d   = LS_WAIT;
                        ls_wren_d = i_ls_wren;
                    end
                end
            end
            IF_WAIT: begin
                if (i_m_rvalid) begin
                    state_d = IDLE;
                    if (!i_if_flush) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = i_m_rdata;
                    end
                end else if (i_if_flush) begin
                    state_d = IF_DROP;
                end
            end
            IF_DROP: begin
                if (i_m_rvalid) state_d = IDLE;
            end
            LS_WAIT: begin
                if (i_m_rvalid) begin
                    state_d  = IDLE;
                    ls_ack_d = 1'b1;
                    if (!ls_wren_q) ls_rdata_d = i_m_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request: driven from the winner only while IDLE with something to issue.
    always_comb begin
        m_req = 1'b0;
        req   = '0;
        if (state_q == IDLE && (if_v || ls_v)) begin
            m_req = 1'b1;
            if (winner == ARB_IF) begin
                req.wren  = 1'b0;
                req.addr  = i_if_addr;
                req.bmask = '1;
            end else begin
                req.wren  = i_ls_wren;
                req.addr  = i_ls_addr;
                req.wdata = i_ls_wdata;
                req.bmask = i_ls_bmask;
            end
        end
    end

    assign o_m_req     = m_req;
    assign o_m_wren    = req.wren;
    assign o_m_addr    = req.addr;
    assign o_m_wdata   = req.wdata;
    assign o_m_bmask   = req.bmask;
    assign o_if_ack    = if_ack_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_ack    = ls_ack_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_stall_if  = if_v;
    assign o_stall_mem = ls_v;

    // A completion with nothing in flight is a memory protocol error; the FSM ignores it.
    a_rvalid_in_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_m_rvalid && state_q == IDLE));

endmodule
